// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// The bus phase helper lets logic ask "is a transaction outstanding" without decoding states.
package bus_pkg;

    localparam logic BUS_IDLE        = 1'b0;
    localparam logic BUS_WAIT        = 1'b1;
    localparam int   TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_IFU = 2'd1,
        ST_WAIT_LSU = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } master_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } bus_req_t;

    function automatic logic bus_phase(input arb_state_e s);
        return (s == ST_IDLE) ? BUS_IDLE : BUS_WAIT;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Wait-cycle counter for an outstanding bus transaction.
// Cleared on grant, advanced on every unanswered wait cycle; expired flags the last allowed cycle.
module bus_timer
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] TERMINAL = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == TERMINAL);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory slave between fetch (IFU) and load/store (LSU) masters.
// One outstanding transaction at a time; a silent slave is cut off after TIMEOUT wait cycles.
//
//   state       | meaning
//   ST_IDLE     | no transaction; grant a requester combinationally
//   ST_WAIT_IFU | fetch outstanding; waiting for slave response or timeout
//   ST_WAIT_LSU | load/store outstanding; waiting for slave response or timeout
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifuReqValid,
    input  logic [31:0] ifuAddr,
    output logic        ifuRespValid,
    output logic [31:0] ifuRdata,
    output logic        ifuErr,
    input  logic        lsuReqValid,
    input  logic [31:0] lsuAddr,
    input  logic        lsuWen,
    input  logic [31:0] lsuWdata,
    input  logic [3:0]  lsuWmask,
    output logic        lsuRespValid,
    output logic [31:0] lsuRdata,
    output logic        lsuErr,
    output logic        memReqValid,
    output logic [31:0] memAddr,
    output logic        memWen,
    output logic [31:0] memWdata,
    output logic [3:0]  memWmask,
    input  logic        memRespValid,
    input  logic [31:0] memRdata
);

    arb_state_e  state_q, state_d;
    master_e     last_q, last_d, grant_id;
    bus_req_t    lat_q, lat_d, ifu_req, lsu_req, mem_req;
    logic        grant, in_wait, expired, timer_tick, done, rsp_err;
    logic [31:0] rsp_data;
    logic        mem_valid, ifu_rv, ifu_e, lsu_rv, lsu_e;
    logic [31:0] ifu_rd, lsu_rd;

    assign ifu_req = '{addr: ifuAddr, wen: 1'b0, wdata: 32'd0, wmask: 4'd0};
    assign lsu_req = '{addr: lsuAddr, wen: lsuWen, wdata: lsuWdata, wmask: lsuWmask};

    // A slave response wins over a coinciding timeout, so err only when the slave stayed silent.
    assign in_wait    = (bus_phase(state_q) == BUS_WAIT);
    assign timer_tick = in_wait && !memRespValid;
    assign done       = in_wait && (memRespValid || expired);
    assign rsp_err    = !memRespValid && expired;
    assign rsp_data   = memRespValid ? memRdata : 32'd0;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (grant),
        .tick    (timer_tick),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        lat_d     = lat_q;
        grant     = 1'b0;
        grant_id  = MST_IFU;
        mem_req   = lat_q;
        mem_valid = 1'b0;
        ifu_rv    = 1'b0;
        ifu_e     = 1'b0;
        ifu_rd    = '0;
        lsu_rv    = 1'b0;
        lsu_e     = 1'b0;
        lsu_rd    = '0;
        case (state_q)
            ST_IDLE: begin
                if (ifuReqValid || lsuReqValid) begin
                    grant = 1'b1;
                    if (ifuReqValid && lsuReqValid) begin
                        grant_id = (last_q == MST_LSU) ? MST_IFU : MST_LSU;
                    end else begin
                        grant_id = ifuReqValid ? MST_IFU : MST_LSU;
                    end
                    mem_req   = (grant_id == MST_IFU) ? ifu_req : lsu_req;
                    mem_valid = 1'b1;
                    lat_d     = mem_req;
                    last_d    = grant_id;
                    state_d   = (grant_id == MST_IFU) ? ST_WAIT_IFU : ST_WAIT_LSU;
                end
            end
            ST_WAIT_IFU: begin
                ifu_rv = done;
                ifu_e  = done && rsp_err;
                ifu_rd = rsp_data;
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LSU: begin
                lsu_rv = done;
                lsu_e  = done && rsp_err;
                lsu_rd = rsp_data;
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // lastGrant resets to LSU so the first tie goes to the fetch side.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= MST_LSU;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lat_q   <= lat_d;
        end
    end

    // Outputs are forced low during reset because the IDLE grant path is combinational.
    assign memReqValid  = mem_valid && !reset;
    assign memAddr      = reset ? 32'd0 : mem_req.addr;
    assign memWen       = mem_req.wen && !reset;
    assign memWdata     = reset ? 32'd0 : mem_req.wdata;
    assign memWmask     = reset ? 4'd0 : mem_req.wmask;
    assign ifuRespValid = ifu_rv && !reset;
    assign ifuErr       = ifu_e && !reset;
    assign ifuRdata     = reset ? 32'd0 : ifu_rd;
    assign lsuRespValid = lsu_rv && !reset;
    assign lsuErr       = lsu_e && !reset;
    assign lsuRdata     = reset ? 32'd0 : lsu_rd;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: grant table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clock, reset;
    logic        ifuReqValid, ifuRespValid, ifuErr;
    logic [31:0] ifuAddr, ifuRdata;
    logic        lsuReqValid, lsuWen, lsuRespValid, lsuErr;
    logic [31:0] lsuAddr, lsuWdata, lsuRdata;
    logic [3:0]  lsuWmask;
    logic        memReqValid, memWen, memRespValid;
    logic [31:0] memAddr, memWdata, memRdata;
    logic [3:0]  memWmask;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .ifuReqValid  (ifuReqValid),
        .ifuAddr      (ifuAddr),
        .ifuRespValid (ifuRespValid),
        .ifuRdata     (ifuRdata),
        .ifuErr       (ifuErr),
        .lsuReqValid  (lsuReqValid),
        .lsuAddr      (lsuAddr),
        .lsuWen       (lsuWen),
        .lsuWdata     (lsuWdata),
        .lsuWmask     (lsuWmask),
        .lsuRespValid (lsuRespValid),
        .lsuRdata     (lsuRdata),
        .lsuErr       (lsuErr),
        .memReqValid  (memReqValid),
        .memAddr      (memAddr),
        .memWen       (memWen),
        .memWdata     (memWdata),
        .memWmask     (memWmask),
        .memRespValid (memRespValid),
        .memRdata     (memRdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ireq;
        logic        lreq;
        logic [31:0] iaddr;
        logic [31:0] laddr;
        logic        lwen;
        logic [31:0] lwdata;
        logic [3:0]  lwmask;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic [3:0]  e_wmask;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ifuReqValid  = 1'b0;
        ifuAddr      = '0;
        lsuReqValid  = 1'b0;
        lsuAddr      = '0;
        lsuWen       = 1'b0;
        lsuWdata     = '0;
        lsuWmask     = '0;
        memRespValid = 1'b0;
        memRdata     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    // Reference model state: one outstanding transaction, round-robin memory, wait age.
    logic        m_busy, m_owner, m_last, m_wen;
    int          m_age;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;

    initial begin
        int          pulses;
        logic        i_pend, l_pend, g;
        logic        e_mreq, e_wen, e_irv, e_ierr, e_lrv, e_lerr;
        logic [31:0] e_addr, e_wdata, e_ird, e_lrd;
        logic [3:0]  e_wmask;

        clear_inputs();
        reset = 1'b1;
        ifuReqValid  = 1'b1;
        lsuReqValid  = 1'b1;
        ifuAddr      = 32'h1234_5678;
        lsuAddr      = 32'h9ABC_DEF0;
        lsuWen       = 1'b1;
        lsuWdata     = 32'hFFFF_FFFF;
        lsuWmask     = 4'hF;
        memRespValid = 1'b1;
        memRdata     = 32'hFFFF_FFFF;
        #3;
        chk("reset_mem_ctl", 32'({memReqValid, memWen, memWmask}), 32'd0);
        chk("reset_mem_data", memAddr | memWdata, 32'd0);
        chk("reset_resp_ctl", 32'({ifuRespValid, ifuErr, lsuRespValid, lsuErr}), 32'd0);
        chk("reset_rdata", ifuRdata | lsuRdata, 32'd0);
        cyc();

        // Single-cycle grant decisions from the reset state (lastGrant = LSU).
        vt[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h1, 4'h1,
                  1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
        vt[1] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h1, 4'h1,
                  1'b1, 32'h0000_1000, 1'b0, 32'h0, 4'h0};
        vt[2] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0200, 1'b1, 32'h55AA_55AA, 4'h3,
                  1'b1, 32'h0000_0200, 1'b1, 32'h55AA_55AA, 4'h3};
        vt[3] = '{1'b1, 1'b1, 32'h0000_3000, 32'h0000_0400, 1'b0, 32'h1111_1111, 4'hC,
                  1'b1, 32'h0000_3000, 1'b0, 32'h0, 4'h0};
        vt[4] = '{1'b0, 1'b1, 32'h0000_5000, 32'h0000_0404, 1'b0, 32'hFFFF_FFFF, 4'h0,
                  1'b1, 32'h0000_0404, 1'b0, 32'hFFFF_FFFF, 4'h0};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            ifuReqValid = vt[i].ireq;
            lsuReqValid = vt[i].lreq;
            ifuAddr     = vt[i].iaddr;
            lsuAddr     = vt[i].laddr;
            lsuWen      = vt[i].lwen;
            lsuWdata    = vt[i].lwdata;
            lsuWmask    = vt[i].lwmask;
            #1;
            chk($sformatf("tbl%0d_req", i), 32'(memReqValid), 32'(vt[i].e_req));
            chk($sformatf("tbl%0d_addr", i), memAddr, vt[i].e_addr);
            chk($sformatf("tbl%0d_wen_mask", i), 32'({memWen, memWmask}),
                32'({vt[i].e_wen, vt[i].e_wmask}));
            chk($sformatf("tbl%0d_wdata", i), memWdata, vt[i].e_wdata);
            cyc();
            chk($sformatf("tbl%0d_wait_req", i), 32'(memReqValid), 32'd0);
            chk($sformatf("tbl%0d_hold_addr", i), memAddr, vt[i].e_addr);
        end

        // Fetch only, slave answers in the fourth cycle counting the grant as cycle 1.
        do_reset();
        ifuReqValid = 1'b1;
        ifuAddr     = 32'h8000_0000;
        pulses      = 0;
        for (int c = 1; c <= 4; c++) begin
            memRespValid = (c == 4);
            memRdata     = (c == 4) ? 32'h0000_0013 : 32'h0;
            #1;
            if (memReqValid) pulses++;
            if (c == 1) chk("fetch_grant_addr", memAddr, 32'h8000_0000);
            if (c < 4) chk("fetch_early_resp", 32'(ifuRespValid), 32'd0);
            cyc();
        end
        // Response was seen combinationally in cycle 4; re-sample it by replaying nothing:
        // the check below verifies the response cycle directly.
        do_reset();
        ifuReqValid = 1'b1;
        ifuAddr     = 32'h8000_0000;
        cyc();
        cyc();
        cyc();
        memRespValid = 1'b1;
        memRdata     = 32'h0000_0013;
        #1;
        chk("fetch_resp_valid", 32'(ifuRespValid), 32'd1);
        chk("fetch_rdata", ifuRdata, 32'h0000_0013);
        chk("fetch_err", 32'({ifuErr, lsuRespValid}), 32'd0);
        chk("fetch_req_pulses", 32'(pulses), 32'd1);
        cyc();
        clear_inputs();
        #1;
        chk("fetch_after_resp", 32'({ifuRespValid, memReqValid}), 32'd0);

        // Simultaneous requests after reset: IFU first, LSU the cycle after ifuRespValid.
        do_reset();
        ifuReqValid = 1'b1;
        ifuAddr     = 32'h0000_0010;
        lsuReqValid = 1'b1;
        lsuAddr     = 32'h0000_0020;
        #1;
        chk("tie_first_ifu", memAddr, 32'h0000_0010);
        cyc();
        memRespValid = 1'b1;
        memRdata     = 32'h0000_000A;
        #1;
        chk("tie_ifu_resp", 32'({ifuRespValid, lsuRespValid, memReqValid}), 32'b100);
        cyc();
        ifuReqValid  = 1'b0;
        memRespValid = 1'b0;
        #1;
        chk("tie_lsu_grant", 32'(memReqValid), 32'd1);
        chk("tie_lsu_addr", memAddr, 32'h0000_0020);
        cyc();
        memRespValid = 1'b1;
        memRdata     = 32'h0000_0B0B;
        #1;
        chk("tie_lsu_resp", lsuRdata, 32'h0000_0B0B);
        cyc();
        clear_inputs();

        // Store: fields stable through WAIT, response on the third WAIT cycle.
        do_reset();
        lsuReqValid = 1'b1;
        lsuAddr     = 32'h0000_0100;
        lsuWen      = 1'b1;
        lsuWdata    = 32'hDEAD_BEEF;
        lsuWmask    = 4'hF;
        #1;
        chk("store_grant", 32'({memReqValid, memWen, memWmask}), 32'h3F);
        cyc();
        for (int c = 0; c < 3; c++) begin
            memRespValid = (c == 2);
            memRdata     = 32'h0000_0077;
            #1;
            chk("store_hold_addr", memAddr, 32'h0000_0100);
            chk("store_hold_wdata", memWdata, 32'hDEAD_BEEF);
            chk("store_hold_ctl", 32'({memReqValid, memWen, memWmask}), 32'h1F);
            chk("store_resp", 32'({lsuRespValid, lsuErr, ifuRespValid}), (c == 2) ? 32'b100 : 32'b000);
            cyc();
        end
        clear_inputs();

        // Silent slave: error on the 4th WAIT cycle; a late response is ignored.
        do_reset();
        lsuReqValid = 1'b1;
        lsuAddr     = 32'h0000_0040;
        cyc();
        for (int c = 1; c <= TO; c++) begin
            #1;
            chk("to_resp_ctl", 32'({lsuRespValid, lsuErr}), (c == TO) ? 32'b11 : 32'b00);
            if (c == TO) chk("to_rdata", lsuRdata, 32'd0);
            cyc();
        end
        lsuReqValid  = 1'b0;
        memRespValid = 1'b1;
        memRdata     = 32'h0000_0099;
        #1;
        chk("to_late_ignored", 32'({lsuRespValid, ifuRespValid, memReqValid}), 32'd0);
        chk("to_late_rdata", lsuRdata | ifuRdata, 32'd0);
        cyc();
        clear_inputs();

        // Response coinciding with the timeout cycle is a normal response.
        do_reset();
        lsuReqValid = 1'b1;
        lsuAddr     = 32'h0000_0044;
        cyc();
        cyc();
        cyc();
        cyc();
        memRespValid = 1'b1;
        memRdata     = 32'h0000_005A;
        #1;
        chk("coincide_ctl", 32'({lsuRespValid, lsuErr}), 32'b10);
        chk("coincide_rdata", lsuRdata, 32'h0000_005A);
        cyc();
        clear_inputs();

        // Reset in WAIT_LSU aborts silently; the held request is then granted again.
        do_reset();
        lsuReqValid = 1'b1;
        lsuAddr     = 32'h0000_0C00;
        cyc();
        cyc();
        reset        = 1'b1;
        memRespValid = 1'b1;
        memRdata     = 32'h0000_00EE;
        #1;
        chk("rst_mid_resp", 32'({lsuRespValid, lsuErr, ifuRespValid, memReqValid}), 32'd0);
        cyc();
        reset        = 1'b0;
        memRespValid = 1'b0;
        #1;
        chk("rst_regrant", 32'(memReqValid), 32'd1);
        chk("rst_regrant_addr", memAddr, 32'h0000_0C00);
        cyc();
        memRespValid = 1'b1;
        #1;
        chk("rst_regrant_resp", 32'({lsuRespValid, lsuErr}), 32'b10);
        cyc();
        clear_inputs();

        // Continuous requests from both: grants alternate IFU, LSU, ...
        do_reset();
        ifuReqValid = 1'b1;
        ifuAddr     = 32'h0000_AAA0;
        lsuReqValid = 1'b1;
        lsuAddr     = 32'h0000_BBB0;
        for (int k = 0; k < 6; k++) begin
            memRespValid = 1'b0;
            #1;
            chk($sformatf("rr%0d_grant", k), memAddr, (k % 2 == 0) ? 32'h0000_AAA0 : 32'h0000_BBB0);
            cyc();
            memRespValid = 1'b1;
            #1;
            chk($sformatf("rr%0d_resp", k), 32'({ifuRespValid, lsuRespValid}),
                (k % 2 == 0) ? 32'b10 : 32'b01);
            cyc();
        end
        clear_inputs();

        // Randomized traffic against the reference model.
        do_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_age   = 0;
        m_addr  = '0;
        m_wen   = 1'b0;
        m_wdata = '0;
        m_wmask = '0;
        i_pend  = 1'b0;
        l_pend  = 1'b0;
        for (int n = 0; n < 3000 && errors < 20; n++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend  = 1'b1;
                ifuAddr = $urandom;
            end
            if (!l_pend && $urandom_range(0, 1) == 1) begin
                l_pend   = 1'b1;
                lsuAddr  = $urandom;
                lsuWen   = 1'($urandom_range(0, 1));
                lsuWdata = $urandom;
                lsuWmask = 4'($urandom_range(0, 15));
            end
            ifuReqValid  = i_pend;
            lsuReqValid  = l_pend;
            memRespValid = ($urandom_range(0, 3) == 0);
            memRdata     = $urandom;

            e_mreq = 1'b0;
            e_irv  = 1'b0;
            e_ierr = 1'b0;
            e_ird  = '0;
            e_lrv  = 1'b0;
            e_lerr = 1'b0;
            e_lrd  = '0;
            if (!m_busy) begin
                if (i_pend || l_pend) begin
                    g       = (i_pend && l_pend) ? !m_last : !i_pend;
                    m_addr  = g ? lsuAddr : ifuAddr;
                    m_wen   = g ? lsuWen : 1'b0;
                    m_wdata = g ? lsuWdata : 32'd0;
                    m_wmask = g ? lsuWmask : 4'd0;
                    m_owner = g;
                    m_last  = g;
                    m_busy  = 1'b1;
                    m_age   = 0;
                    e_mreq  = 1'b1;
                end
            end else if (memRespValid || m_age == TO - 1) begin
                if (m_owner) begin
                    e_lrv  = 1'b1;
                    e_lerr = !memRespValid;
                    e_lrd  = memRespValid ? memRdata : 32'd0;
                end else begin
                    e_irv  = 1'b1;
                    e_ierr = !memRespValid;
                    e_ird  = memRespValid ? memRdata : 32'd0;
                end
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
            e_addr  = m_addr;
            e_wen   = m_wen;
            e_wdata = m_wdata;
            e_wmask = m_wmask;

            #1;
            chk("rnd_mem_req", 32'(memReqValid), 32'(e_mreq));
            chk("rnd_mem_addr", memAddr, e_addr);
            chk("rnd_mem_wen_mask", 32'({memWen, memWmask}), 32'({e_wen, e_wmask}));
            chk("rnd_mem_wdata", memWdata, e_wdata);
            chk("rnd_resp_ctl", 32'({ifuRespValid, ifuErr, lsuRespValid, lsuErr}),
                32'({e_irv, e_ierr, e_lrv, e_lerr}));
            chk("rnd_ifu_rdata", ifuRdata, e_ird);
            chk("rnd_lsu_rdata", lsuRdata, e_lrd);
            if (e_irv) i_pend = 1'b0;
            if (e_lrv) l_pend = 1'b0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
